pts_step_sequencer: RTL
=======================

# pts_step_sequencer

Clocked pulse-sequence scheduler that drives a 32-channel pulse-timing-system (PTS) code bus. Host software loads a table of steps, each a 32-bit channel code plus a dwell time. On start, the block plays the table in order: each step advances either after its dwell count expires or, when its dwell is 0, on an external trigger edge. It replaces asynchronous, trigger-clocked index stepping with a single-clock state machine and sits between the host register interface and the channel output drivers.

## Interface
- MAX_STEP, 8, table depth in steps (1..256)
- iClk  in  1  system clock, all logic on rising edge
- iRst  in  1  reset, synchronous and active-high
- iWrEn  in  1  table write strobe, one write per cycle
- iWrAddr  in  8  step index to write
- iWrCode  in  32  channel code for the step
- iWrDwell  in  32  dwell in iClk cycles; 0 = wait for trigger
- iLength  in  8  number of steps to play, sampled on accepted start
- iLoop  in  1  1 = restart at step 0 after the last step, sampled on accepted start
- iStart  in  1  start request, level-sampled
- iAbort  in  1  stop immediately
- iTrigger  in  1  external trigger, already synchronous to iClk
- oCode  out  32  active channel code; 0 when not running
- oIndex  out  8  current step index
- oBusy  out  1  sequence running
- oDone  out  1  one-cycle pulse at normal completion
- oErr  out  1  one-cycle pulse on a rejected write or start

## Operation
- Table: MAX_STEP entries of {code[31:0], dwell[31:0]}, held in flops. Reset clears all entries to 0.
- Writes:
  - Accepted only in IDLE with iWrAddr < MAX_STEP.
  - A write while busy, or with an out-of-range address, is dropped and oErr pulses the next cycle.
- States:
  - IDLE: oCode=0, oBusy=0. Transitions to RUN or WAIT_TRIG on an accepted start.
  - RUN: dwell counter active.
  - WAIT_TRIG: dwell=0; waiting for a trigger edge.
- Start:
  - Accepted in IDLE when 1 ≤ iLength ≤ MAX_STEP; iLength and iLoop are latched.
  - Otherwise the start is dropped and oErr pulses.
  - iStart while busy is ignored, with no error.
- Step entry k: oIndex=k, oCode=code[k]. Next state is RUN with the counter loaded with dwell[k] if dwell[k]≠0, else WAIT_TRIG.
- Trigger edge: iTrigger=1 while the registered previous iTrigger=0. The previous-value register resets to 0. Edges outside WAIT_TRIG are ignored and not queued.
- End of the last step (k = latched length−1):
  - iLoop=1: enter step 0; no oDone.
  - iLoop=0: return to IDLE and pulse oDone.
- iAbort in any state: IDLE on the next cycle, oCode=0, oIndex=0, no oDone. If iAbort and iStart arrive in the same cycle, abort wins.
- A write to the table while busy is impossible (rejected), so playback is glitch-free.
- Dwell is 32-bit unsigned with no wrap; a step lasts at most 2^32−1 cycles.

## Timing
- All outputs are registered.
- Reset values: oCode=0, oIndex=0, oBusy=0, oDone=0, oErr=0, state IDLE.
- Start accepted at cycle s: step 0 is visible at s+1 (oBusy=1).
- Step entered at cycle e with dwell D≥1: oCode=code[k] for cycles e..e+D−1; the next step, or IDLE, is visible at e+D.
- WAIT_TRIG: a trigger edge at cycle t puts the next step visible at t+1. An edge in the entry cycle e itself counts.
- Completion: in the cycle the machine returns to IDLE, oCode=0, oBusy=0, oDone=1 (one cycle only).
- oErr asserts in the cycle after the rejected request, for one cycle.
- iRst mid-sequence: outputs take reset values on the next edge and the table is cleared.

## Test plan
- Write steps 0..2 = {0xA,3},{0xB,1},{0xC,2}, iLength=3, iLoop=0, start at cycle s -> oCode 0xA for s+1..s+3, 0xB for s+4, 0xC for s+5..s+6; oDone=1 and oCode=0 at s+7.
- Same table with iLoop=1 -> 0xA reappears at s+7, oDone stays 0. iAbort at s+9 -> at s+10 oCode=0, oBusy=0, no oDone.
- Step 1 dwell=0, iTrigger held high from before entry, then toggled low and high at t -> no advance until the rising edge at t; step 2 visible at t+1.
- Write while busy, write to addr=MAX_STEP, start with iLength=0, start with iLength=MAX_STEP+1 -> each gives a one-cycle oErr, the table is unchanged, and state is unchanged.
- iStart and iAbort together in IDLE -> stays IDLE, oBusy=0. iStart during RUN -> ignored, sequence timing unchanged.
- iRst pulsed mid-RUN -> next cycle all outputs 0. Reading back via a start with iLength=1 shows code 0, and oDone pulses 1 cycle after entering WAIT_TRIG plus a trigger edge.

Source files
------------

// File: rtl/pts_step_sequencer.sv
// Step sequencer for a 32-channel PTS code bus: plays a table of
// {code, dwell} steps, advancing on dwell expiry or on a trigger edge.
//
// Ports:
//   iClk, iRst         clock, synchronous active-high reset
//   iWrEn/iWrAddr/
//   iWrCode/iWrDwell   table write port, accepted only while idle
//   iLength, iLoop     step count and loop flag, latched on start
//   iStart, iAbort     start request, immediate stop
//   iTrigger           synchronous trigger, rising edge advances dwell-0 steps
//   oCode, oIndex      active channel code and step index
//   oBusy, oDone, oErr running flag, completion pulse, reject pulse
module pts_step_sequencer #(
  parameter int MAX_STEP = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iWrEn,
  input  logic [7:0]  iWrAddr,
  input  logic [31:0] iWrCode,
  input  logic [31:0] iWrDwell,
  input  logic [7:0]  iLength,
  input  logic        iLoop,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iTrigger,
  output logic [31:0] oCode,
  output logic [7:0]  oIndex,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam int IW = (MAX_STEP > 1) ? $clog2(MAX_STEP) : 1;
  localparam logic [8:0] DEPTH = 9'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_TRIG = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic        loop_q, loop_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        trig_q;

  logic [31:0] tab_code  [MAX_STEP];
  logic [31:0] tab_dwell [MAX_STEP];

  logic        idle;
  logic        wr_ok;
  logic        wr_bad;
  logic        len_ok;
  logic        start_req;
  logic        start_ok;
  logic        step_end;
  logic        last;
  logic        enter;
  logic [7:0]  enter_idx;
  logic [IW-1:0] sel;

  assign idle      = (state_q == IDLE);
  assign wr_ok     = iWrEn && idle && ({1'b0, iWrAddr} < DEPTH);
  assign wr_bad    = iWrEn && !wr_ok;
  assign len_ok    = (iLength != 8'd0) && ({1'b0, iLength} <= DEPTH);
  // Abort outranks start, so a start cut short by abort is not an error.
  assign start_req = iStart && idle && !iAbort;
  assign start_ok  = start_req && len_ok;
  assign last      = (index_q == len_q - 8'd1);
  assign step_end  = ((state_q == RUN) && (cnt_q == 32'd1)) ||
                     ((state_q == WAIT_TRIG) && iTrigger && !trig_q);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    loop_d    = loop_q;
    done_d    = 1'b0;
    err_d     = wr_bad || (start_req && !len_ok);
    enter     = 1'b0;
    enter_idx = 8'd0;
    sel       = '0;

    if (iAbort) begin
      state_d = IDLE;
      code_d  = 32'd0;
      index_d = 8'd0;
      cnt_d   = 32'd0;
    end else if (start_ok) begin
      len_d  = iLength;
      loop_d = iLoop;
      enter  = 1'b1;
    end else if (step_end) begin
      if (!last) begin
        enter     = 1'b1;
        enter_idx = index_q + 8'd1;
      end else if (loop_q) begin
        enter = 1'b1;
      end else begin
        state_d = IDLE;
        code_d  = 32'd0;
        index_d = 8'd0;
        cnt_d   = 32'd0;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - 32'd1;
    end

    // The counter holds the cycles left in the step including the
    // current one, so a step of dwell D ends when it reads 1.
    if (enter) begin
      sel     = enter_idx[IW-1:0];
      code_d  = tab_code[sel];
      index_d = enter_idx;
      cnt_d   = tab_dwell[sel];
      state_d = (tab_dwell[sel] != 32'd0) ? RUN : WAIT_TRIG;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      code_q  <= 32'd0;
      index_q <= 8'd0;
      cnt_q   <= 32'd0;
      len_q   <= 8'd0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trig_q  <= iTrigger;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < MAX_STEP; i++) begin
        tab_code[i]  <= 32'd0;
        tab_dwell[i] <= 32'd0;
      end
    end else if (wr_ok) begin
      tab_code[iWrAddr[IW-1:0]]  <= iWrCode;
      tab_dwell[iWrAddr[IW-1:0]] <= iWrDwell;
    end
  end

  assign oCode  = code_q;
  assign oIndex = index_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;
  assign oErr   = err_q;

endmodule
